// File: rtl/fetch_stage_pkg.sv
// Shared widths, F_D_bus field layout and bus structs for the fetch stage
// and its neighbours (Decode, CTRL, core top).
package fetch_stage_pkg;

   localparam int unsigned F_D_WID  = 35;
   localparam int unsigned BRAN_WID = 33;

   localparam int unsigned FD_ADEL_BIT = 34;
   localparam int unsigned FD_DS_BIT   = 33;
   localparam int unsigned FD_CE_BIT   = 32;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFBF_FFFC;

   typedef struct packed {
      logic        br_en;
      logic [31:0] br_addr;
   } bran_t;

   typedef struct packed {
      logic        adel;
      logic        delayslot;
      logic        ce;
      logic [31:0] pc;
   } f_d_t;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, drives the instruction SRAM and
// forwards {F_adel, delayslot, ce, pc} to Decode.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          stall,
   input  logic                flush,
   input  logic [31:0]         new_pc,
   input  logic [BRAN_WID-1:0] bran_bus,
   input  logic                next_delayslot_judge_i,
   output logic                inst_sram_en,
   output logic [3:0]          inst_sram_wen,
   output logic [31:0]         inst_sram_addr,
   output logic [31:0]         inst_sram_wdata,
   output logic [F_D_WID-1:0]  F_D_bus
);

   bran_t       bran;
   logic [31:0] pc_r, pc_nxt;
   logic        ce_r;
   logic        br_pend, br_pend_nxt;
   logic [31:0] br_tgt, br_tgt_nxt;
   logic        f_adel;
   logic        unused_stall;
   f_d_t        fd;

   assign bran         = bran_t'(bran_bus);
   assign unused_stall = ^stall[5:1];

   // Redirect priority: flush > stall (latch branch) > live branch > deferred branch > pc+4
   always_comb begin
      pc_nxt      = pc_r + 32'd4;
      br_pend_nxt = br_pend;
      br_tgt_nxt  = br_tgt;
      if (flush) begin
         pc_nxt      = new_pc;
         br_pend_nxt = 1'b0;
      end else if (stall[0]) begin
         pc_nxt = pc_r;
         if (bran.br_en) begin
            br_pend_nxt = 1'b1;
            br_tgt_nxt  = bran.br_addr;
         end
      end else if (bran.br_en) begin
         pc_nxt      = bran.br_addr;
         br_pend_nxt = 1'b0;
      end else if (br_pend) begin
         pc_nxt      = br_tgt;
         br_pend_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r    <= RESET_PC;
         ce_r    <= 1'b0;
         br_pend <= 1'b0;
         br_tgt  <= '0;
      end else begin
         pc_r    <= pc_nxt;
         ce_r    <= 1'b1;
         br_pend <= br_pend_nxt;
         br_tgt  <= br_tgt_nxt;
      end
   end

   assign f_adel          = ce_r & misaligned(pc_r);
   assign inst_sram_en    = ce_r & ~f_adel;
   assign inst_sram_wen   = '0;
   assign inst_sram_addr  = pc_r;
   assign inst_sram_wdata = '0;

   always_comb begin
      fd.adel      = f_adel;
      fd.delayslot = next_delayslot_judge_i;
      fd.ce        = ce_r;
      fd.pc        = pc_r;
   end

   assign F_D_bus = fd;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: each step queues the expected
// post-edge state, advances one clock and checks the DUT outputs against it.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic                clk;
   logic                rst;
   logic [5:0]          stall;
   logic                flush;
   logic [31:0]         new_pc;
   logic [BRAN_WID-1:0] bran_bus;
   logic                next_delayslot_judge_i;
   logic                inst_sram_en;
   logic [3:0]          inst_sram_wen;
   logic [31:0]         inst_sram_addr;
   logic [31:0]         inst_sram_wdata;
   logic [F_D_WID-1:0]  F_D_bus;

   int unsigned n_cmp;
   int unsigned n_bad;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        ce;
      logic        adel;
      logic        ds;
   } exp_t;

   exp_t sb[$];

   fetch_stage #(.RESET_PC(32'hBFBF_FFFC)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .stall                  (stall),
      .flush                  (flush),
      .new_pc                 (new_pc),
      .bran_bus               (bran_bus),
      .next_delayslot_judge_i (next_delayslot_judge_i),
      .inst_sram_en           (inst_sram_en),
      .inst_sram_wen          (inst_sram_wen),
      .inst_sram_addr         (inst_sram_addr),
      .inst_sram_wdata        (inst_sram_wdata),
      .F_D_bus                (F_D_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_head();
      exp_t e;
      logic [F_D_WID-1:0] bus;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL scoreboard: observed empty queue expected entry");
         return;
      end
      e   = sb.pop_front();
      bus = {e.adel, e.ds, e.ce, e.pc};
      cmp({e.tag, ".F_D_bus"}, 64'(F_D_bus), 64'(bus));
      cmp({e.tag, ".sram_en"}, 64'(inst_sram_en), 64'(e.ce & ~e.adel));
      cmp({e.tag, ".sram_addr"}, 64'(inst_sram_addr), 64'(e.pc));
      cmp({e.tag, ".sram_wen"}, 64'(inst_sram_wen), 64'(0));
      cmp({e.tag, ".sram_wdata"}, 64'(inst_sram_wdata), 64'(0));
   endtask

   task automatic step(input string tag, input logic [31:0] pc, input logic ce, input logic adel);
      exp_t e;
      e.tag  = tag;
      e.pc   = pc;
      e.ce   = ce;
      e.adel = adel;
      e.ds   = next_delayslot_judge_i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_head();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      stall = '0;
      flush = 1'b0;
      new_pc = '0;
      bran_bus = '0;
      next_delayslot_judge_i = 1'b0;

      // Reset release
      step("rst0", 32'hBFBF_FFFC, 1'b0, 1'b0);
      step("rst1", 32'hBFBF_FFFC, 1'b0, 1'b0);
      step("rst2", 32'hBFBF_FFFC, 1'b0, 1'b0);
      rst = 1'b0;
      step("boot0", 32'hBFC0_0000, 1'b1, 1'b0);
      step("boot1", 32'hBFC0_0004, 1'b1, 1'b0);
      step("boot2", 32'hBFC0_0008, 1'b1, 1'b0);
      step("boot3", 32'hBFC0_000C, 1'b1, 1'b0);
      step("boot4", 32'hBFC0_0010, 1'b1, 1'b0);

      // Branch without stall, resolved while pc = BFC0_0010
      bran_bus = {1'b1, 32'hBFC0_0100};
      step("br", 32'hBFC0_0100, 1'b1, 1'b0);
      bran_bus = '0;
      step("br+4", 32'hBFC0_0104, 1'b1, 1'b0);

      // Return to BFC0_0010 via flush
      flush = 1'b1; new_pc = 32'hBFC0_0010;
      step("fl10", 32'hBFC0_0010, 1'b1, 1'b0);
      flush = 1'b0;

      // Branch during a 3-cycle stall is deferred
      stall = 6'b000001; bran_bus = {1'b1, 32'hBFC0_0200};
      step("stbr0", 32'hBFC0_0010, 1'b1, 1'b0);
      bran_bus = '0;
      step("stbr1", 32'hBFC0_0010, 1'b1, 1'b0);
      step("stbr2", 32'hBFC0_0010, 1'b1, 1'b0);
      stall = '0;
      step("stbr_rel", 32'hBFC0_0200, 1'b1, 1'b0);
      step("stbr+4", 32'hBFC0_0204, 1'b1, 1'b0);

      // Flush beats stall, concurrent branch and pending branch
      stall = 6'b000001; bran_bus = {1'b1, 32'hBFC0_0300};
      step("pend", 32'hBFC0_0204, 1'b1, 1'b0);
      flush = 1'b1; new_pc = 32'hBFC0_0380; bran_bus = {1'b1, 32'hBFC0_0340};
      step("flall", 32'hBFC0_0380, 1'b1, 1'b0);
      flush = 1'b0; bran_bus = '0;
      step("flhold", 32'hBFC0_0380, 1'b1, 1'b0);
      stall = '0;
      step("flnojmp0", 32'hBFC0_0384, 1'b1, 1'b0);
      step("flnojmp1", 32'hBFC0_0388, 1'b1, 1'b0);

      // Misaligned branch target
      bran_bus = {1'b1, 32'hBFC0_0102};
      step("adel0", 32'hBFC0_0102, 1'b1, 1'b1);
      bran_bus = '0;
      step("adel1", 32'hBFC0_0106, 1'b1, 1'b1);
      flush = 1'b1; new_pc = 32'hBFC0_0380;
      step("adelfl", 32'hBFC0_0380, 1'b1, 1'b0);
      flush = 1'b0;

      // Delay-slot flag is combinational
      next_delayslot_judge_i = 1'b1;
      #1;
      cmp("ds_comb1", 64'(F_D_bus[FD_DS_BIT]), 64'(1));
      step("ds1", 32'hBFC0_0384, 1'b1, 1'b0);
      next_delayslot_judge_i = 1'b0;
      #1;
      cmp("ds_comb0", 64'(F_D_bus[FD_DS_BIT]), 64'(0));
      step("ds0", 32'hBFC0_0388, 1'b1, 1'b0);

      // PC wraps modulo 2^32; upper stall bits do not freeze fetch
      flush = 1'b1; new_pc = 32'hFFFF_FFFC;
      step("wrapfl", 32'hFFFF_FFFC, 1'b1, 1'b0);
      flush = 1'b0; stall = 6'b111110;
      step("wrap", 32'h0000_0000, 1'b1, 1'b0);
      stall = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch pipeline stage. Holds the architectural PC, drives the instruction SRAM, and hands `{F_adel, delayslot, ce, pc}` to Decode via `F_D_bus`. It sits directly upstream of Decode.

- Applies branch redirects resolved in Decode, remembering a redirect that arrives while Fetch is stalled.
- Applies CTRL flush/exception redirects.
- Detects misaligned fetch addresses.

## Interface
Parameters:
- `RESET_PC`, default `32'hBFBF_FFFC`: PC value held during reset. The first real fetch is `RESET_PC+4` = `32'hBFC0_0000`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `stall`  in  6: CTRL stall vector. Bit 0 freezes Fetch.
- `flush`  in  1: CTRL flush.
- `new_pc`  in  32: CTRL redirect target (exception entry or ERET), valid with `flush`.
- `bran_bus`  in  `Bran_Wid` (33): `{br_en, br_addr}` from Decode.
- `next_delayslot_judge_i`  in  1: Decode currently holds a branch/jump.
- `inst_sram_en`  out  1: SRAM read enable.
- `inst_sram_wen`  out  4: constant 0.
- `inst_sram_addr`  out  32: fetch address.
- `inst_sram_wdata`  out  32: constant 0.
- `F_D_bus`  out  `F_D_Wid` (35): `{F_adel, delayslot_judge, ce, pc}`, bits 34, 33, 32, 31:0.

## Operation
Registers:
- `pc_r` (32 bits)
- `ce_r`
- `br_pend`
- `br_tgt` (32 bits)

Next-PC priority, highest first:
1. `rst`: `pc_r`=`RESET_PC`, `ce_r`=0, `br_pend`=0, `br_tgt`=0.
2. `flush`: `pc_r`=`new_pc`, `br_pend`=0. Applies even when `stall[0]`=1. Discards any pending or concurrent branch.
3. `stall[0]`: `pc_r` holds.
   - If `br_en`=1: `br_pend`=1, `br_tgt`=`br_addr`. A later `br_en` during the same stall overwrites `br_tgt` with the latest value.
4. `br_en`: `pc_r`=`br_addr`, `br_pend`=0.
5. `br_pend`: `pc_r`=`br_tgt`, `br_pend`=0.
6. Otherwise: `pc_r`=`pc_r`+4, modulo 2^32. `32'hFFFF_FFFC` wraps to 0.

Other register and output behaviour:
- `ce_r` is set to 1 on the first non-reset cycle and stays at 1.
- `F_adel` = `ce_r` & (`pc_r[1:0]` != 0), combinational.
- `inst_sram_en` = `ce_r` & ~`F_adel`.
- `inst_sram_addr` = `pc_r`.
- The SRAM is not written: `inst_sram_wen` and `inst_sram_wdata` are constant 0.
- `delayslot_judge` = `next_delayslot_judge_i`, combinational. The instruction in Fetch while Decode holds a branch is its delay slot.
- The delay slot is always fetched. A redirect from `br_en` only ever replaces the PC *after* the slot.

## Timing
- Outputs during reset: `pc_r`=`RESET_PC`, `ce`=0, `F_adel`=0, `inst_sram_en`=0.
- Cycle 1 after `rst` deasserts: `pc`=`32'hBFC0_0000`, `ce`=1.
- The SRAM is synchronous-read. The instruction for `pc` appears on `inst_sram_rdata` the cycle after `pc` is presented, aligned with Decode's registered copy of `F_D_bus`.
- Branch redirect latency: a branch resolved in cycle N (`br_en`=1, `stall[0]`=0) gives `pc`=`br_addr` in cycle N+1.
- Deferred branch: redirect during a stall is applied on the first edge with `stall[0]`=0. The delay slot at `pc_r` is still delivered to Decode before the target.
- Flush latency: `flush` in cycle N gives `pc`=`new_pc` in cycle N+1, regardless of stall state.
- Misaligned PC: with `pc_r[1:0]`≠0, the stage raises `F_adel`=1 and keeps `inst_sram_en`=0. The PC continues to advance normally until the flush from CTRL arrives.
- There is no internal handshake. `stall` is the only backpressure; `F_D_bus` is valid whenever `ce`=1.

## Structure
- `lib/Defines.vh` holds the following, shared with Decode, CTRL and mycpu_core:
  - `` `F_D_Wid`` = 35
  - `` `Bran_Wid`` = 33
  - `` `RESET_PC``
  - the `F_D_bus` field offsets
- No sub-module. The design is a single flat module, roughly 120–160 lines.

## Test plan
1. **Reset release:** `rst` for 3 cycles, then low → `pc`=`BFBF_FFFC`/`ce`=0 during reset; `BFC0_0000`, `BFC0_0004`, `BFC0_0008` on the following cycles.
2. **Branch, no stall:** `br_en`=1 with `br_addr`=`BFC0_0100`, applied while `pc`=`BFC0_0010` → next `pc`=`BFC0_0100`, then `BFC0_0104`.
3. **Branch during stall:** `stall[0]`=1 for 3 cycles; `br_en` pulses in the 1st cycle with `BFC0_0200`; `pc` is `BFC0_0010` → `pc` holds `BFC0_0010` for 3 cycles, then becomes `BFC0_0200` one edge after release.
4. **Flush vs stall and branch:** `flush`=1, `new_pc`=`BFC0_0380`, with `stall[0]`=1, `br_en`=1 and `br_pend`=1 all at once → next `pc`=`BFC0_0380`, `br_pend`=0, and no later jump to the old target.
5. **Misaligned target:** `br_en` with `br_addr`=`BFC0_0102` → next cycle `F_adel`=1 and `inst_sram_en`=0; a following `flush` to `BFC0_0380` clears `F_adel`.
6. **Delay-slot flag:** `next_delayslot_judge_i`=1 → `F_D_bus[33]`=1 in the same cycle, and 0 when the input drops.
